// File: rtl/image_cell_sequencer_pkg.sv
// image_cell_sequencer_pkg: cell, operand, opcode and sequencer-state types for the cell processing core
package CellProcessingPkg;
  typedef logic [7:0] cell_t;
  typedef logic [7:0] userInput_t;
  typedef enum logic [2:0] {SEQ_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR} opcodes_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} seq_state_t;
endpackage

// File: rtl/image_cell_sequencer_if.sv
// cellProcessor_int: link between the image sequencer and the cell processor
//   imagePorts: image side drives cellA, cellB, userInputA, opcode
//   procPorts:  processor side consumes those and drives processedCell
interface cellProcessor_int;
  import CellProcessingPkg::*;
  cell_t      cellA;
  cell_t      cellB;
  cell_t      processedCell;
  userInput_t userInputA;
  opcodes_t   opcode;
  modport imagePorts (output cellA, cellB, userInputA, opcode);
  modport procPorts (input cellA, cellB, userInputA, opcode, output processedCell);
endinterface

// File: rtl/image_cell_sequencer_tracker.sv
// cell_pipe_tracker: shift register of {valid, addr} following each read through to its write
//   clr_i       drops every in-flight entry
//   v_i/addr_i  read issued this cycle
//   first_v_o   read data is on the buffer outputs now
//   cap_v_o     processed result is on processed_cell now
//   head_v_o/head_addr_o  entry whose result is written this cycle
//   empty_o     nothing in flight behind the head entry
module cell_pipe_tracker #(
  parameter int DEPTH = 5,
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         v_i,
  input  logic [W-1:0] addr_i,
  output logic         first_v_o,
  output logic         cap_v_o,
  output logic         head_v_o,
  output logic [W-1:0] head_addr_o,
  output logic         empty_o
);
  logic [DEPTH-1:0]        v_q;
  logic [DEPTH-1:0][W-1:0] a_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v_q <= '0;
      a_q <= '0;
    end else begin
      v_q <= clr_i ? '0 : {v_q[DEPTH-2:0], v_i};
      a_q <= {a_q[DEPTH-2:0], addr_i};
    end
  assign first_v_o   = v_q[0];
  assign cap_v_o     = v_q[DEPTH-2];
  assign head_v_o    = v_q[DEPTH-1];
  assign head_addr_o = a_q[DEPTH-1];
  // the head is being written this cycle, so only the stages behind it still hold work
  assign empty_o     = ~|v_q[DEPTH-2:0];
endmodule

// File: rtl/image_cell_sequencer.sv
// image_cell_sequencer: streams buffer A/B cell pairs into the cell processor and writes results back
//   start/abort/num_cells/op_in/user_in  run control, fields sampled on an accepted start
//   rd_en/rd_addr/rd_data_a/rd_data_b    buffer reads, data one cycle after rd_en
//   cp/processed_cell                    cell processor operands out, result in
//   wr_en/wr_addr/wr_data                result buffer writes
//   busy/done                            run status
module image_cell_sequencer
  import CellProcessingPkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int PROC_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W:0]      num_cells,
  input  opcodes_t             op_in,
  input  userInput_t           user_in,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  cell_t                rd_data_a,
  input  cell_t                rd_data_b,
  cellProcessor_int.imagePorts cp,
  input  cell_t                processed_cell,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output cell_t                wr_data,
  output logic                 busy,
  output logic                 done
);
  localparam int DEPTH = PROC_LAT + 3;
  seq_state_t        state_q, state_d;
  logic [ADDR_W:0]   num_q, num_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  opcodes_t          op_q, op_d;
  userInput_t        user_q, user_d;
  cell_t             cell_a_q, cell_b_q, wr_data_q;
  logic              last, cell_v, cap_v, drained;
  // compare in ADDR_W+1 bits so a full 2**ADDR_W image stops at all-ones instead of wrapping
  assign last = {1'b0, addr_q} == num_q - (ADDR_W+1)'(1);
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    addr_d  = addr_q;
    op_d    = op_q;
    user_d  = user_q;
    if (abort) state_d = S_IDLE;
    else if (state_q == S_IDLE && start) begin
      state_d = num_cells == '0 ? S_DONE : S_ISSUE;
      num_d   = num_cells;
      addr_d  = '0;
      op_d    = op_in;
      user_d  = user_in;
    end else if (state_q == S_ISSUE) begin
      state_d = last ? S_DRAIN : S_ISSUE;
      addr_d  = last ? addr_q : addr_q + ADDR_W'(1);
    end else if (state_q == S_DRAIN) state_d = drained ? S_DONE : S_DRAIN;
    else if (state_q == S_DONE) state_d = S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      addr_q  <= '0;
      op_q    <= SEQ_NOP;
      user_q  <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      user_q  <= user_d;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cell_a_q  <= '0;
      cell_b_q  <= '0;
      wr_data_q <= '0;
    end else begin
      cell_a_q  <= cell_v ? rd_data_a : cell_a_q;
      cell_b_q  <= cell_v ? rd_data_b : cell_b_q;
      wr_data_q <= cap_v ? processed_cell : wr_data_q;
    end
  cell_pipe_tracker #(.DEPTH(DEPTH), .W(ADDR_W)) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (abort),
    .v_i        (rd_en),
    .addr_i     (addr_q),
    .first_v_o  (cell_v),
    .cap_v_o    (cap_v),
    .head_v_o   (wr_en),
    .head_addr_o(wr_addr),
    .empty_o    (drained)
  );
  assign rd_en         = state_q == S_ISSUE;
  assign rd_addr       = addr_q;
  assign busy          = state_q != S_IDLE;
  assign done          = state_q == S_DONE;
  assign wr_data       = wr_data_q;
  assign cp.cellA      = cell_a_q;
  assign cp.cellB      = cell_b_q;
  assign cp.userInputA = user_q;
  assign cp.opcode     = op_q;
endmodule

// File: tb/tb_image_cell_sequencer.sv
// tb_image_cell_sequencer: directed and randomized runs against a timing/data model of the sequencer
module tb_image_cell_sequencer;
  import CellProcessingPkg::*;
  localparam int AW = 3;
  localparam int P = 2;
  logic          clk, rst, start, abort;
  logic [AW:0]   num_cells;
  opcodes_t      op_in;
  userInput_t    user_in;
  logic          rd_en, wr_en, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  cell_t         rd_data_a, rd_data_b, processed_cell, wr_data;
  cell_t         mem_a [8];
  cell_t         mem_b [8];
  cell_t         pp [P];
  int            checks, errors;
  cellProcessor_int cpi ();
  image_cell_sequencer #(.ADDR_W(AW), .PROC_LAT(P)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .num_cells     (num_cells),
    .op_in         (op_in),
    .user_in       (user_in),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data_a     (rd_data_a),
    .rd_data_b     (rd_data_b),
    .cp            (cpi),
    .processed_cell(processed_cell),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  // image buffers: registered read, data one cycle after rd_en
  always @(posedge clk)
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr];
      rd_data_b <= mem_b[rd_addr];
    end
  // cell processor: A + B + userInputA, PROC_LAT cycles after the operands
  always @(posedge clk) begin
    pp[0] <= cpi.cellA + cpi.cellB + cpi.userInputA;
    for (int i = 1; i < P; i++) pp[i] <= pp[i-1];
  end
  assign cpi.processedCell = pp[P-1];
  assign processed_cell = cpi.processedCell;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // one run, checked every cycle; abort_k/restart_k > 0 inject abort / a stray start in that cycle
  task automatic run(input int n, input int abort_k, input int restart_k);
    opcodes_t op = opcodes_t'($urandom_range(1, 5));
    userInput_t u = 8'($urandom);
    int dk = (n == 0) ? 1 : n + P + 4;
    bit ab = 0;
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
    @(negedge clk);
    start = 1;
    num_cells = (AW+1)'(n);
    op_in = op;
    user_in = u;
    for (int k = 1; k <= dk + 2; k++) begin
      @(negedge clk);
      start = 0;
      abort = 0;
      num_cells = (AW+1)'($urandom_range(0, 8));
      op_in = opcodes_t'($urandom_range(1, 5));
      user_in = 8'($urandom);
      if (abort_k > 0 && k == abort_k + 1) ab = 1;
      begin
        bit rd_e = !ab && k <= n;
        bit wr_e = !ab && k >= P + 4 && k <= n + P + 3;
        int wi = k - P - 4;
        chk("rd_en", 32'(rd_en), 32'(rd_e));
        if (rd_e) chk("rd_addr", 32'(rd_addr), k - 1);
        chk("wr_en", 32'(wr_en), 32'(wr_e));
        if (wr_e) begin
          chk("wr_addr", 32'(wr_addr), wi);
          chk("wr_data", 32'(wr_data), 32'(8'(mem_a[wi] + mem_b[wi] + u)));
        end
        chk("done", 32'(done), 32'(!ab && k == dk));
        if (k != dk) chk("busy", 32'(busy), 32'(!ab && n > 0 && k < dk));
        chk("opcode", 32'(cpi.opcode), 32'(op));
        chk("userInputA", 32'(cpi.userInputA), 32'(u));
      end
      if (k == abort_k) abort = 1;
      if (k == restart_k && k < dk) start = 1;
    end
    @(negedge clk);
    abort = 0;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst = 1;
    start = 0;
    abort = 0;
    num_cells = '0;
    op_in = OP_ADD;
    user_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_opcode", 32'(cpi.opcode), 32'(SEQ_NOP));
    rst = 0;
    run(4, 0, 0);
    run(0, 0, 0);
    run(4, 0, 3);
    run(8, P + 5, 0);
    run(8, 0, 0);
    run(8, 0, 0);
    // asynchronous reset in the middle of ISSUE
    @(negedge clk);
    start = 1;
    num_cells = (AW+1)'(8);
    op_in = OP_XOR;
    user_in = 8'h5a;
    repeat (3) @(negedge clk);
    start = 0;
    chk("pre_rst_rd_en", 32'(rd_en), 1);
    rst = 1;
    #1;
    chk("arst_rd_en", 32'(rd_en), 0);
    chk("arst_rd_addr", 32'(rd_addr), 0);
    chk("arst_wr_en", 32'(wr_en), 0);
    chk("arst_wr_addr", 32'(wr_addr), 0);
    chk("arst_wr_data", 32'(wr_data), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_opcode", 32'(cpi.opcode), 32'(SEQ_NOP));
    chk("arst_userInputA", 32'(cpi.userInputA), 0);
    chk("arst_cellA", 32'(cpi.cellA), 0);
    chk("arst_cellB", 32'(cpi.cellB), 0);
    @(negedge clk);
    rst = 0;
    repeat (8) begin
      int n = $urandom_range(0, 8);
      int ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
      int rk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
      run(n, ak, rk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
